// File: rtl/entry_pkg.sv
// Shared types and constants for the decimal operand entry block.
// Optional build macro used by the top level: ENTRY_ECHO_EN.
package entry_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } state_t;

    localparam logic [3:0] BCD_MAX          = 4'd9;
    localparam logic [7:0] SAT_VAL          = 8'd255;
    localparam int         DEBOUNCE_DEFAULT = 1024;

    // Wide enough that three digits can never wrap before the saturation test.
    function automatic logic [11:0] acc_step(input logic [7:0] acc,
                                             input logic [3:0] digit);
        return ({4'd0, acc} * 12'd10) + {8'd0, digit};
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Pushbutton conditioning: 2-flop synchronizer, stability counter and
// a one-cycle pulse on each accepted press.
module btn_debounce
    import entry_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic rise
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1;
    logic          s2;
    logic          level;
    logic          level_q;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1      <= 1'b0;
            s2      <= 1'b0;
            level   <= 1'b0;
            level_q <= 1'b0;
            cnt     <= '0;
            rise    <= 1'b0;
        end else begin
            s1      <= raw;
            s2      <= s1;
            level_q <= level;
            rise    <= level & ~level_q;
            // Any return to the accepted level restarts the stability window.
            if (s2 == level) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                cnt   <= '0;
                level <= s2;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/decimal_entry.sv
// Decimal operand entry: collects BCD digits from the switches and delivers
// an 8-bit value over valid/ack. Build macro: ENTRY_ECHO_EN (live echo).
module decimal_entry
    import entry_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int MAX_DIGITS      = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req,
    input  logic [3:0] sw,
    input  logic       btn_digit,
    input  logic       btn_enter,
    input  logic       ack,
    output logic       inp_take,
    output logic [7:0] value,
    output logic       valid,
    output logic [1:0] ndigits,
    output logic       err
);

    localparam logic [1:0] MAX_N = 2'(MAX_DIGITS);

    state_t      state;
    state_t      state_n;
    logic [7:0]  acc;
    logic [7:0]  acc_n;
    logic [7:0]  value_n;
    logic [1:0]  nd_n;
    logic        err_n;
    logic [11:0] step;
    logic        dig_ev;
    logic        ent_ev;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dig (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (btn_digit),
        .rise  (dig_ev)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ent (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (btn_enter),
        .rise  (ent_ev)
    );

    assign inp_take = (state == COLLECT);
    assign valid    = (state == HOLD);
    assign step     = acc_step(acc, sw);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            acc     <= '0;
            value   <= '0;
            ndigits <= '0;
            err     <= 1'b0;
        end else begin
            state   <= state_n;
            acc     <= acc_n;
            value   <= value_n;
            ndigits <= nd_n;
            err     <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        acc_n   = acc;
        value_n = value;
        nd_n    = ndigits;
        err_n   = err;
        unique case (state)
            IDLE: begin
                if (req) begin
                    acc_n   = '0;
                    nd_n    = '0;
                    err_n   = 1'b0;
                    state_n = COLLECT;
                end
            end
            COLLECT: begin
                if (!req) begin
                    state_n = IDLE;
                end else begin
                    if (dig_ev) begin
                        if ((sw > BCD_MAX) || (ndigits == MAX_N)) begin
                            err_n = 1'b1;
                        end else begin
                            nd_n = ndigits + 2'd1;
                            if (step > {4'd0, SAT_VAL}) begin
                                acc_n = SAT_VAL;
                                err_n = 1'b1;
                            end else begin
                                acc_n = step[7:0];
                            end
                        end
                    end
`ifdef ENTRY_ECHO_EN
                    value_n = acc_n;
`endif
                    // Same-cycle digit is already folded into acc_n.
                    if (ent_ev) begin
                        value_n = acc_n;
                        state_n = HOLD;
                    end
                end
            end
            HOLD: begin
                if (ack) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_decimal_entry.sv
// Self-checking bench for decimal_entry: table vectors, random entries
// against an arithmetic model, and hand-written corner sequences.
module tb_decimal_entry;

    localparam int D = 16;
    localparam int HOLD_CYC = D + 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req = 1'b0;
    logic [3:0] sw = 4'd0;
    logic       btn_digit = 1'b0;
    logic       btn_enter = 1'b0;
    logic       ack = 1'b0;
    logic       inp_take;
    logic [7:0] value;
    logic       valid;
    logic [1:0] ndigits;
    logic       err;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [3:0] d [4];
        int         n;
        int         exp_val;
        int         exp_nd;
        int         exp_err;
    } vec_t;

    decimal_entry #(.DEBOUNCE_CYCLES(D), .MAX_DIGITS(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .sw        (sw),
        .btn_digit (btn_digit),
        .btn_enter (btn_enter),
        .ack       (ack),
        .inp_take  (inp_take),
        .value     (value),
        .valid     (valid),
        .ndigits   (ndigits),
        .err       (err)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input bit enter);
        if (enter) btn_enter = 1'b1;
        else       btn_digit = 1'b1;
        repeat (HOLD_CYC) tick();
        btn_enter = 1'b0;
        btn_digit = 1'b0;
        repeat (HOLD_CYC) tick();
    endtask

    // Plain arithmetic on the list of keyed digits.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        int val = 0;
        int nd = 0;
        int e = 0;
        for (int i = 0; i < v.n; i++) begin
            int dg = int'(v.d[i]);
            if (dg > 9 || nd == 3) begin
                e = 1;
            end else begin
                val = val * 10 + dg;
                if (val > 255) begin
                    val = 255;
                    e = 1;
                end
                nd++;
            end
        end
        r.exp_val = val;
        r.exp_nd = nd;
        r.exp_err = e;
        return r;
    endfunction

    task automatic do_entry(input vec_t v, input bit keep_req);
        req = 1'b1;
        tick();
        chk("take_rise", inp_take, 1);
        for (int i = 0; i < v.n; i++) begin
            sw = v.d[i];
            press(1'b0);
        end
        press(1'b1);
        chk("valid_hi", valid, 1);
        chk("value", value, v.exp_val);
        chk("ndigits", ndigits, v.exp_nd);
        chk("err", err, v.exp_err);
        chk("take_hold", inp_take, 0);
        repeat (3) tick();
        chk("value_stable", value, v.exp_val);
        chk("valid_stable", valid, 1);
        ack = 1'b1;
        if (!keep_req) req = 1'b0;
        tick();
        ack = 1'b0;
        chk("valid_after_ack", valid, 0);
        if (keep_req) begin
            chk("idle_take", inp_take, 0);
            tick();
            chk("restart_take", inp_take, 1);
            chk("restart_nd", ndigits, 0);
            chk("restart_err", err, 0);
            req = 1'b0;
            tick();
        end
        tick();
    endtask

    vec_t tbl [8];

    initial begin
        tbl[0] = '{'{4'd1, 4'd2, 4'd3, 4'd0}, 3, 123, 3, 0};
        tbl[1] = '{'{4'd2, 4'd5, 4'd6, 4'd0}, 3, 255, 3, 1};
        tbl[2] = '{'{4'hA, 4'd7, 4'd0, 4'd0}, 2, 7, 1, 1};
        tbl[3] = '{'{4'd1, 4'd2, 4'd3, 4'd4}, 4, 123, 3, 1};
        tbl[4] = '{'{4'd0, 4'd0, 4'd0, 4'd0}, 0, 0, 0, 0};
        tbl[5] = '{'{4'd0, 4'd0, 4'd9, 4'd0}, 3, 9, 3, 0};
        tbl[6] = '{'{4'd9, 4'd9, 4'd0, 4'd0}, 2, 99, 2, 0};
        tbl[7] = '{'{4'd3, 4'd0, 4'd0, 4'd0}, 3, 255, 3, 1};

        #12;
        chk("rst_take", inp_take, 0);
        chk("rst_valid", valid, 0);
        chk("rst_value", value, 0);
        chk("rst_nd", ndigits, 0);
        chk("rst_err", err, 0);
        rst_n = 1'b1;
        repeat (3) tick();

        for (int i = 0; i < 8; i++) begin
            do_entry(tbl[i], 1'b0);
        end

        // Saturating entry with req left high so the restart clears err.
        do_entry(tbl[1], 1'b1);

        // Glitch then bounce: only the final stable press counts.
        req = 1'b1;
        tick();
        sw = 4'd4;
        btn_digit = 1'b1;
        repeat (10) tick();
        btn_digit = 1'b0;
        repeat (HOLD_CYC) tick();
        chk("glitch_nd", ndigits, 0);
        for (int i = 0; i < 12; i++) begin
            btn_digit = ~btn_digit;
            repeat (5) tick();
        end
        press(1'b0);
        chk("bounce_nd", ndigits, 1);
        press(1'b1);
        chk("bounce_value", value, 4);
        chk("bounce_err", err, 0);
        ack = 1'b1;
        req = 1'b0;
        tick();
        ack = 1'b0;
        tick();

        // Abort mid-entry: valid must never appear.
        begin
            int seen = 0;
            req = 1'b1;
            tick();
            sw = 4'd5;
            press(1'b0);
            chk("abort_nd", ndigits, 1);
            req = 1'b0;
            for (int i = 0; i < 40; i++) begin
                tick();
                if (valid) seen++;
            end
            chk("abort_valid", seen, 0);
            chk("abort_take", inp_take, 0);
        end

        // Enter pressed in IDLE is discarded, not queued.
        press(1'b1);
        req = 1'b1;
        repeat (20) tick();
        chk("idle_ev_valid", valid, 0);
        chk("idle_ev_take", inp_take, 1);
        req = 1'b0;
        repeat (2) tick();

        // Randomized entries against the arithmetic model.
        for (int k = 0; k < 12; k++) begin
            vec_t v;
            v.n = int'($urandom_range(0, 4));
            for (int i = 0; i < 4; i++) v.d[i] = 4'($urandom_range(0, 11));
            v = model(v);
            do_entry(v, 1'b0);
        end

        // Asynchronous reset while holding a result.
        req = 1'b1;
        tick();
        sw = 4'd4;
        press(1'b0);
        sw = 4'd2;
        press(1'b1 ^ 1'b1);
        press(1'b1);
        chk("pre_rst_valid", valid, 1);
        chk("pre_rst_value", value, 42);
        req = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_valid", valid, 0);
        chk("async_value", value, 0);
        chk("async_nd", ndigits, 0);
        chk("async_take", inp_take, 0);
        #10;
        rst_n = 1'b1;
        repeat (2) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decimal_entry.md
# decimal_entry

Decimal user-input front end for the GPC board. While the processor requests an operand, it collects up to three decimal digits from four BCD slide switches and two raw pushbuttons. It converts the digits to an 8-bit binary value and hands the value to the processor over a valid/ack handshake. Its `inp_take` output drives the seven-segment display's input prompt, which makes this block the entry-side counterpart of the display's binary-to-decimal path.

## Interface
- `DEBOUNCE_CYCLES`, 1024: number of consecutive stable `clk` cycles required before a button level is accepted.
- `MAX_DIGITS`, 3: maximum number of digits accepted per entry.
- `clk` in 1: system clock; the only clock in the block.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req` in 1: processor requests an operand; level-sensitive.
- `sw` in 4: BCD digit from the slide switches; asynchronous to `clk`, sampled only on a digit event.
- `btn_digit` in 1: raw pushbutton that appends `sw` as the next digit.
- `btn_enter` in 1: raw pushbutton that completes the entry.
- `ack` in 1: processor has consumed `value`.
- `inp_take` out 1: high while the block is collecting digits.
- `value` out 8: binary result.
- `valid` out 1: `value` is ready for the processor.
- `ndigits` out 2: number of digits accepted so far in the current entry.
- `err` out 1: sticky flag for a rejected or saturated digit; cleared when a new entry starts.

## Operation
- Each button passes through a 2-flop synchronizer and then a stability counter.
  - The debounced level changes only after the synchronized input has held a new level for `DEBOUNCE_CYCLES` cycles.
  - A rising edge of the debounced level produces a one-cycle event: `dig_ev` or `ent_ev`.
- State machine with states IDLE, COLLECT, HOLD.
  - **IDLE:** `inp_take`=0, `valid`=0. When `req`=1: clear `acc`, `ndigits` and `err`, then go to COLLECT.
  - **COLLECT:** `inp_take`=1.
    - On `dig_ev` with `sw`>9: ignore the digit and set `err`.
    - On `dig_ev` with `ndigits`==`MAX_DIGITS`: ignore the digit and set `err`.
    - On any other `dig_ev`: `acc` = `acc`*10 + `sw`, computed at 12-bit width. If the result exceeds 255, `acc` saturates to 255 and `err` is set. `ndigits` increments.
    - On `ent_ev`: `value`←`acc`, `valid`←1, go to HOLD.
    - If `req` drops: go to IDLE without asserting `valid`.
  - **HOLD:** `inp_take`=0, `valid`=1, `value` stable. On `ack`=1: go to IDLE, and `valid` deasserts on the next edge.
- `dig_ev` and `ent_ev` in the same cycle: the digit is applied first, and the delivered `value` includes it.
- `ent_ev` with zero digits delivers `value`=0.
- Button events in IDLE or HOLD are discarded; they are never queued.
- `ack` outside HOLD is ignored.
- `req` held high after `ack`: a new entry starts on the cycle after the block returns to IDLE.
- Reset values: `inp_take`=0, `value`=0, `valid`=0, `ndigits`=0, `err`=0, state IDLE.
- Assertion of `rst_n` forces the reset values immediately, in any state and mid-debounce. The debounce counters clear and the debounced levels clear to 0 (released).

## Timing
- Button latency: a clean press becomes an event 2 (sync) + `DEBOUNCE_CYCLES` + 1 (edge) cycles after the first sampling edge.
- `acc` and `ndigits` update on the edge following `dig_ev`.
- `valid` rises on the edge following `ent_ev`.
- IDLE→COLLECT: `inp_take` rises one cycle after `req` is sampled high.
- HOLD→IDLE: `valid` falls one cycle after `ack` is sampled high.
- A release also needs `DEBOUNCE_CYCLES` of stability. Pressing again before the release has been accepted produces no new event.

## Configuration
- `ENTRY_ECHO_EN` defined: during COLLECT, `value` follows `acc` every cycle, so the display can echo digits as they are typed. `valid` behaviour is unchanged.
- `ENTRY_ECHO_EN` undefined: `value` changes only on `ent_ev` or reset, and holds the last delivered result otherwise.

## Structure
- Shared package `entry_pkg` holds:
  - the state encoding (IDLE=2'd0, COLLECT=2'd1, HOLD=2'd2);
  - `BCD_MAX`=9;
  - `SAT_VAL`=8'd255;
  - the default `DEBOUNCE_CYCLES`.
- Sub-module `btn_debounce` (synchronizer, stability counter, rising-edge pulse), instantiated once per button.
- The FSM and accumulator live in the top level.

## Test plan
- Use `DEBOUNCE_CYCLES`=16 in the bench.
- **Basic entry:** `req`=1, digits 1, 2, 3, then enter → `value`=123, `valid`=1, `ndigits`=3, `err`=0. Values hold until `ack`; `valid`=0 the cycle after `ack`.
- **Saturation:** digits 2, 5, 6, then enter → `value`=255, `err`=1.
- **Invalid digit:** `sw`=4'hA, digit press → `ndigits` unchanged, `err`=1. Then digit 7 and enter → `value`=7.
- **Bounce:** `btn_digit` toggles every 5 cycles for 60 cycles, then holds high → exactly one digit accepted. A 10-cycle glitch produces no event.
- **Limits:** a fourth digit after three is ignored and sets `err`. Enter with no digits → `value`=0, `valid`=1.
- **Abort and reset:** dropping `req` mid-entry → IDLE, `valid` never asserts. Asserting `rst_n` low during HOLD → `valid`=0 and `value`=0 immediately, without waiting for a clock edge.
